pht_sat_array: RTL and testbench

Parametrised pattern history table of saturating counters for the branch prediction unit.
- Multiple combinational read ports for fetch-stage lookup.
- Registered read-modify-write update port driven by branch commit: taken/not-taken, not a raw counter value.
- Multi-cycle clear state machine for predictor flush.
- Optional gshare index hashing with an internal global history register.

---
 rtl/bpu_pkg.sv | 28 ++
 rtl/pht_ghr.sv | 39 +++
 rtl/pht_sat_array.sv | 143 ++++++++++++++
 tb/tb_pht_sat_array.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
// Saturating-counter arithmetic is width-generic via an explicit width argument.
package bpu_pkg;

    typedef enum logic {
        PHT_IDLE  = 1'b0,
        PHT_CLEAR = 1'b1
    } pht_state_e;

    localparam int PHT_ENTRIES   = 64;
    localparam int PHT_CNT_MAX_W = 16;

    // Callers zero-extend their counter to PHT_CNT_MAX_W and pass their CNT_W localparam as cnt_w.
    function automatic logic [PHT_CNT_MAX_W-1:0] sat_next(
        input logic [PHT_CNT_MAX_W-1:0] cnt,
        input logic                     taken,
        input int                       cnt_w
    );
        logic [PHT_CNT_MAX_W-1:0] max_v;
        max_v = PHT_CNT_MAX_W'((32'd1 << cnt_w) - 32'd1);
        if (taken) begin
            sat_next = (cnt == max_v) ? cnt : cnt + 1'b1;
        end else begin
            sat_next = (cnt == '0) ? cnt : cnt - 1'b1;
        end
    endfunction

endpackage

// File: rtl/pht_ghr.sv
// Global history register plus XOR index hash; zero latency on the hash path.
// Reads and captures in a shift cycle see the pre-shift history. No backpressure.
module pht_ghr #(
    parameter int IDX_W    = 6,
    parameter int GHR_W    = 6,
    parameter int RD_PORTS = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      shift_vld,
    input  logic                      shift_taken,
    input  logic [RD_PORTS*IDX_W-1:0] rd_idx,
    input  logic [IDX_W-1:0]          upd_idx,
    output logic [RD_PORTS*IDX_W-1:0] rd_idx_hash,
    output logic [IDX_W-1:0]          upd_idx_hash
);

    logic [GHR_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_ext;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ghr_q <= '0;
        end else if (enable) begin
            if (flush) begin
                ghr_q <= '0;
            end else if (shift_vld) begin
                ghr_q <= GHR_W'({ghr_q, shift_taken});
            end
        end
    end

    assign ghr_ext      = IDX_W'(ghr_q);
    assign rd_idx_hash  = rd_idx ^ {RD_PORTS{ghr_ext}};
    assign upd_idx_hash = upd_idx ^ ghr_ext;

endmodule

// File: rtl/pht_sat_array.sv
// Pattern history table of saturating counters: combinational reads, 2-cycle RMW update, multi-cycle clear.
// Updates have no backpressure; updates during a clear are dropped. Optional gshare hashing under PHT_GSHARE_EN.
module pht_sat_array
    import bpu_pkg::*;
#(
    parameter int  ENTRIES  = PHT_ENTRIES,
    parameter int  CNT_W    = 2,
    parameter int  RD_PORTS = 2,
    parameter int  GHR_W    = 6,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_enable,
    input  logic [RD_PORTS-1:0]       i_rd_vld,
    input  logic [RD_PORTS*IDX_W-1:0] i_rd_idx,
    output logic [RD_PORTS*CNT_W-1:0] o_rd_cnt,
    output logic [RD_PORTS-1:0]       o_rd_taken,
    input  logic                      i_upd_vld,
    input  logic [IDX_W-1:0]          i_upd_idx,
    input  logic                      i_upd_taken,
`ifdef PHT_GSHARE_EN
    input  logic                      i_ghr_upd_vld,
    input  logic                      i_ghr_taken,
`endif
    input  logic                      i_flush,
    output logic                      o_busy
);

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] WTK_CNT = CNT_W'(1 << (CNT_W - 1));

    if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("pht_sat_array: ENTRIES must be a power of two >= 4");
    end
    if (CNT_W < 2 || CNT_W > PHT_CNT_MAX_W) begin : g_bad_cnt_w
        $error("pht_sat_array: CNT_W out of range");
    end
    if (RD_PORTS < 1 || GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ports_ghr
        $error("pht_sat_array: RD_PORTS or GHR_W out of range");
    end

    logic [RD_PORTS*IDX_W-1:0] rd_idx_eff;
    logic [IDX_W-1:0]          upd_idx_eff;

`ifdef PHT_GSHARE_EN
    pht_ghr #(
        .IDX_W    (IDX_W),
        .GHR_W    (GHR_W),
        .RD_PORTS (RD_PORTS)
    ) u_ghr (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .enable       (i_enable),
        .flush        (i_flush),
        .shift_vld    (i_ghr_upd_vld),
        .shift_taken  (i_ghr_taken),
        .rd_idx       (i_rd_idx),
        .upd_idx      (i_upd_idx),
        .rd_idx_hash  (rd_idx_eff),
        .upd_idx_hash (upd_idx_eff)
    );
`else
    assign rd_idx_eff  = i_rd_idx;
    assign upd_idx_eff = i_upd_idx;
`endif

    logic [CNT_W-1:0] cnt_tbl [ENTRIES];
    pht_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             u1_vld_q;
    logic [IDX_W-1:0] u1_idx_q;
    logic             u1_taken_q;
    logic [CNT_W-1:0] wr_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= PHT_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // A flush in either state (re)starts the sweep; the pointer wraps to 0 after the last entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (i_enable) begin
            if (i_flush) begin
                state_d = PHT_CLEAR;
                ptr_d   = '0;
            end else if (state_q == PHT_CLEAR) begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = PHT_IDLE;
                end
            end
        end
    end

    assign o_busy = (state_q == PHT_CLEAR);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            u1_vld_q   <= 1'b0;
            u1_idx_q   <= '0;
            u1_taken_q <= 1'b0;
        end else if (i_enable) begin
            u1_vld_q   <= i_upd_vld && !i_flush && (state_q == PHT_IDLE);
            u1_idx_q   <= upd_idx_eff;
            u1_taken_q <= i_upd_taken;
        end
    end

    assign wr_cnt = CNT_W'(sat_next(PHT_CNT_MAX_W'(cnt_tbl[u1_idx_q]), u1_taken_q, CNT_W));

    // The flush cycle suppresses the pending RMW write as well as any clear write.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_tbl[i] <= RST_CNT;
            end
        end else if (i_enable && !i_flush) begin
            if (state_q == PHT_CLEAR) begin
                cnt_tbl[ptr_q] <= RST_CNT;
            end else if (u1_vld_q) begin
                cnt_tbl[u1_idx_q] <= wr_cnt;
            end
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [IDX_W-1:0] idx_p;
        logic [CNT_W-1:0] cnt_p;
        assign idx_p = rd_idx_eff[p*IDX_W +: IDX_W];
        assign cnt_p = (i_rd_vld[p] && state_q == PHT_IDLE) ? cnt_tbl[idx_p] : WTK_CNT;
        assign o_rd_cnt[p*CNT_W +: CNT_W] = cnt_p;
        assign o_rd_taken[p] = cnt_p[CNT_W-1];
    end

endmodule

// File: tb/tb_pht_sat_array.sv
// Self-checking bench for pht_sat_array (ENTRIES=64, CNT_W=2, RD_PORTS=2, GHR_W=6).
// Expected read values are queued when stimulus is driven and popped at the following negedge.
module tb_pht_sat_array;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  rd_vld = '0;
    logic [11:0] rd_idx = '0;
    logic [3:0]  rd_cnt;
    logic [1:0]  rd_taken;
    logic        upd_vld = 1'b0;
    logic [5:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
`ifdef PHT_GSHARE_EN
    logic        ghr_upd_vld = 1'b0;
    logic        ghr_taken = 1'b0;
`endif

    pht_sat_array #(
        .ENTRIES  (64),
        .CNT_W    (2),
        .RD_PORTS (2),
        .GHR_W    (6)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_enable    (enable),
        .i_rd_vld    (rd_vld),
        .i_rd_idx    (rd_idx),
        .o_rd_cnt    (rd_cnt),
        .o_rd_taken  (rd_taken),
        .i_upd_vld   (upd_vld),
        .i_upd_idx   (upd_idx),
        .i_upd_taken (upd_taken),
`ifdef PHT_GSHARE_EN
        .i_ghr_upd_vld (ghr_upd_vld),
        .i_ghr_taken   (ghr_taken),
`endif
        .i_flush     (flush),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];
    logic [1:0] mdl [ENTRIES];
    logic       m_u1_vld;
    logic [5:0] m_u1_idx;
    logic       m_u1_tk;
    logic [1:0] e0, e1;

    function automatic logic [1:0] m_sat(input logic [1:0] c, input logic tk);
        if (tk) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) mdl[i] = 2'b01;
        m_u1_vld = 1'b0;
        m_u1_idx = '0;
        m_u1_tk  = 1'b0;
    endtask

    // Advance one clock; the reference model applies the write of the update captured last edge.
    task automatic tick();
        @(posedge clk);
        if (enable && rstn) begin
            if (m_u1_vld && !flush) mdl[m_u1_idx] = m_sat(mdl[m_u1_idx], m_u1_tk);
            m_u1_vld = upd_vld && !flush && !busy;
            m_u1_idx = upd_idx;
            m_u1_tk  = upd_taken;
        end
        #1;
    endtask

    task automatic set_rd(input logic [1:0] vld, input logic [5:0] i0, input logic [5:0] i1);
        rd_vld = vld;
        rd_idx = {i1, i0};
    endtask

    task automatic push_exp(input logic [1:0] x0, input logic [1:0] x1);
        exp_q.push_back(x0);
        exp_q.push_back(x1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        set_rd(2'b11, 6'd5, 6'd5);
        push_exp(2'b01, 2'b01);
        @(negedge clk);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
        if (rd_cnt !== {e1, e0} || rd_taken !== {e1[1], e0[1]}) begin
            n_err++;
            $display("FAIL reset_rd_vld: cnt %b taken %b, want cnt %b%b", rd_cnt, rd_taken, e1, e0);
        end
        set_rd(2'b00, 6'd5, 6'd5);
        push_exp(2'b10, 2'b10);
        @(negedge clk);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
        if (rd_cnt !== {e1, e0} || rd_taken !== {e1[1], e0[1]}) begin
            n_err++;
            $display("FAIL reset_rd_novld: cnt %b taken %b, want cnt %b%b", rd_cnt, rd_taken, e1, e0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_saturate(input logic tk, input logic [1:0] final_cnt);
        for (int k = 0; k < 8; k++) begin
            upd_vld   = (k < 4);
            upd_idx   = 6'd3;
            upd_taken = tk;
            set_rd(2'b11, 6'd3, 6'd7);
            push_exp(mdl[3], mdl[7]);
            @(negedge clk);
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
            if (rd_cnt !== {e1, e0} || rd_taken !== {e1[1], e0[1]}) begin
                n_err++;
                $display("FAIL saturate_tk%0d cyc %0d: cnt %b taken %b, want cnt %b%b", tk, k, rd_cnt, rd_taken, e1, e0);
            end
            tick();
        end
        upd_vld = 1'b0;
        set_rd(2'b01, 6'd3, 6'd0);
        @(negedge clk);
        n_vec++;
        if (rd_cnt[1:0] !== final_cnt) begin
            n_err++;
            $display("FAIL saturate_final_tk%0d: got %b want %b", tk, rd_cnt[1:0], final_cnt);
        end
        tick();
    endtask

    task automatic test_read_latency();
        logic [1:0] want [3];
        want[0] = 2'b01; want[1] = 2'b01; want[2] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            upd_vld   = (k == 0);
            upd_idx   = 6'd7;
            upd_taken = 1'b1;
            set_rd(2'b10, 6'd0, 6'd7);
            push_exp(2'b10, want[k]);
            @(negedge clk);
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
            if (rd_cnt !== {e1, e0} || rd_taken !== {e1[1], e0[1]}) begin
                n_err++;
                $display("FAIL read_latency T+%0d: cnt %b taken %b, want cnt %b%b", k, rd_cnt, rd_taken, e1, e0);
            end
            tick();
        end
        upd_vld = 1'b0;
    endtask

    task automatic test_flush();
        int busy_cnt;
        for (int k = 0; k < 6; k++) begin
            upd_vld   = (k < 4);
            upd_idx   = (k < 2) ? 6'd0 : 6'd63;
            upd_taken = 1'b1;
            tick();
        end
        upd_vld = 1'b0;
        set_rd(2'b11, 6'd0, 6'd63);
        push_exp(2'b11, 2'b11);
        @(negedge clk);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
        if (rd_cnt !== {e1, e0}) begin
            n_err++;
            $display("FAIL flush_prefill: cnt %b want %b%b", rd_cnt, e1, e0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            push_exp(2'b10, 2'b10);
            @(negedge clk);
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
            if (!busy) break;
            busy_cnt++;
            n_vec++;
            if (rd_cnt !== {e1, e0} || rd_taken !== {e1[1], e0[1]}) begin
                n_err++;
                $display("FAIL flush_busy_rd cyc %0d: cnt %b taken %b, want %b%b", c, rd_cnt, rd_taken, e1, e0);
            end
            upd_vld   = (c == 5);
            upd_idx   = 6'd0;
            upd_taken = 1'b1;
            tick();
        end
        upd_vld = 1'b0;
        n_vec++;
        if (busy_cnt != 64) begin
            n_err++;
            $display("FAIL flush_busy_len: got %0d cycles want 64", busy_cnt);
        end
        model_reset();
        tick();
        for (int i = 0; i < ENTRIES; i++) begin
            set_rd(2'b11, 6'(i), 6'(ENTRIES - 1 - i));
            push_exp(2'b01, 2'b01);
            @(negedge clk);
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
            if (rd_cnt !== {e1, e0}) begin
                n_err++;
                $display("FAIL flush_cleared idx %0d: cnt %b want %b%b", i, rd_cnt, e1, e0);
            end
            tick();
        end
    endtask

    task automatic test_flush_drop();
        int guard;
        upd_vld = 1'b1; upd_idx = 6'd9; upd_taken = 1'b1;
        tick();
        flush = 1'b1; upd_idx = 6'd10;
        tick();
        flush = 1'b0; upd_vld = 1'b0;
        guard = 0;
        while (busy && guard < 200) begin
            tick();
            guard++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drop_timeout: busy still %b", busy);
        end
        model_reset();
        tick();
        set_rd(2'b11, 6'd9, 6'd10);
        push_exp(2'b01, 2'b01);
        @(negedge clk);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
        if (rd_cnt !== {e1, e0}) begin
            n_err++;
            $display("FAIL flush_drop: cnt %b want %b%b", rd_cnt, e1, e0);
        end
        tick();
    endtask

    task automatic test_enable();
        enable = 1'b0;
        upd_vld = 1'b1; upd_idx = 6'd20; upd_taken = 1'b1; flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_rd(2'b01, 6'd20, 6'd0);
            push_exp(2'b01, 2'b10);
            @(negedge clk);
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
            if (busy !== 1'b0 || rd_cnt !== {e1, e0}) begin
                n_err++;
                $display("FAIL enable_hold cyc %0d: busy %b cnt %b, want busy 0 cnt %b%b", k, busy, rd_cnt, e1, e0);
            end
            tick();
        end
        upd_vld = 1'b0; flush = 1'b0;
        enable = 1'b1;
        tick(); tick(); tick();
        set_rd(2'b01, 6'd20, 6'd0);
        push_exp(mdl[20], 2'b10);
        @(negedge clk);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
        if (rd_cnt !== {e1, e0} || e0 !== 2'b01) begin
            n_err++;
            $display("FAIL enable_after: cnt %b want %b%b (and 01 on port0)", rd_cnt, e1, e0);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        upd_vld = 1'b1; upd_idx = 6'd40; upd_taken = 1'b1;
        tick();
        upd_vld = 1'b0;
        tick();
        set_rd(2'b01, 6'd40, 6'd0);
        push_exp(2'b10, 2'b10);
        @(negedge clk);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
        if (rd_cnt !== {e1, e0}) begin
            n_err++;
            $display("FAIL midclear_prefill: cnt %b want %b%b", rd_cnt, e1, e0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #2 rstn = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL midclear_busy: got %b want 0", busy);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
        set_rd(2'b11, 6'd40, 6'd0);
        push_exp(2'b01, 2'b01);
        @(negedge clk);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
        if (rd_cnt !== {e1, e0} || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midclear_state: cnt %b busy %b, want cnt %b%b busy 0", rd_cnt, busy, e1, e0);
        end
        tick();
    endtask

`ifdef PHT_GSHARE_EN
    task automatic test_gshare();
        logic [2:0] hist;
        hist = 3'b101;
        for (int k = 0; k < 3; k++) begin
            ghr_upd_vld = 1'b1;
            ghr_taken   = hist[2-k];
            tick();
        end
        ghr_upd_vld = 1'b0;
        upd_vld = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1;
        tick();
        upd_vld = 1'b0;
        tick();
        set_rd(2'b11, 6'd0, 6'd5);
        push_exp(2'b10, 2'b01);
        @(negedge clk);
        e0 = exp_q.pop_front(); e1 = exp_q.pop_front(); n_vec++;
        if (rd_cnt !== {e1, e0} || rd_taken !== {e1[1], e0[1]}) begin
            n_err++;
            $display("FAIL gshare_hash: cnt %b taken %b, want cnt %b%b", rd_cnt, rd_taken, e1, e0);
        end
        tick();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_saturate(1'b1, 2'b11);
        test_saturate(1'b0, 2'b00);
        test_read_latency();
        test_flush();
        test_flush_drop();
        test_enable();
        test_reset_mid_clear();
`ifdef PHT_GSHARE_EN
        test_gshare();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
